// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan arbiter.
// Segment glyphs are active low and ordered {dp,g,f,e,d,c,b,a}.
package seg_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  localparam logic [3:0] CODE_BLANK = 4'd10;
  localparam logic [3:0] CODE_DASH  = 4'd11;

  // The MSB flags an active owner and the low bits carry the source index.
  typedef enum logic [2:0] {
    OWNER_IDLE = 3'b000,
    OWNER_S0   = 3'b100,
    OWNER_S1   = 3'b101,
    OWNER_S2   = 3'b110,
    OWNER_S3   = 3'b111
  } owner_e;

  function automatic owner_e owner_of(input logic [1:0] src);
    return owner_e'({1'b1, src});
  endfunction

  function automatic logic [7:0] glyph(input logic [3:0] code);
    logic [7:0] seg;
    case (code)
      4'd0:      seg = 8'hC0;
      4'd1:      seg = 8'hF9;
      4'd2:      seg = 8'hA4;
      4'd3:      seg = 8'hB0;
      4'd4:      seg = 8'h99;
      4'd5:      seg = 8'h92;
      4'd6:      seg = 8'h82;
      4'd7:      seg = 8'hF8;
      4'd8:      seg = 8'h80;
      4'd9:      seg = 8'h90;
      CODE_DASH: seg = SEG_DASH;
      default:   seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_decode_ext.sv
// Combinational digit-code to active-low segment decoder with decimal point.
module seg7_decode_ext
  import seg_pkg::*;
(
  input  logic [3:0] code,
  input  logic       dp,
  output logic [7:0] seg
);

  logic [7:0] base;

  always_comb begin
    base = glyph(code);
    seg  = {base[7] & ~dp, base[6:0]};
  end

endmodule

// File: rtl/seg_display_arbiter.sv
// Frame-granular display arbiter for four requesters plus an 8-digit scan
// engine with a blanking interval at the start of every digit slot.
module seg_display_arbiter
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV  = 200000,
  parameter int BLANK_CYCLES = 2000,
  parameter int MIN_HOLD     = 50
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   req,
  input  logic [127:0] src_data,
  input  logic [31:0]  src_dp,
  output logic [3:0]   gnt,
  output logic         frame_tick,
  output logic [7:0]   led_en,
  output logic [7:0]   led_cx
);

  localparam int CNT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int HOLD_W = $clog2(MIN_HOLD + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MIN_HOLD);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        pos_q, pos_d;
  owner_e            owner_q, owner_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [3:0]        gnt_q, gnt_d;
  logic              tick_q, tick_d;
  logic [3:0]        code_q, code_d;
  logic              dp_q, dp_d;
  logic [7:0]        led_en_q, led_en_d;
  logic [7:0]        led_cx_q, led_cx_d;

  logic [3:0] digit_code [4];
  logic [3:0] digit_dp;
  logic [1:0] owner_src;
  logic       owner_active;
  logic [3:0] show_code;
  logic       show_dp;
  logic [7:0] seg_glyph;
  logic       slot_wrap;
  logic       boundary;
  logic       any_req;
  logic [1:0] low_idx;

  // Current digit of every source, selected by the scan pointer.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_src
      assign digit_code[gi] = src_data[32*gi + 4*pos_q +: 4];
      assign digit_dp[gi]   = src_dp[8*gi + pos_q];
    end
  endgenerate

  assign owner_src    = owner_q[1:0];
  assign owner_active = owner_q[2];

  // Slot start uses the live sample so the glyph is right even with no blanking.
  assign show_code = (cnt_q == '0) ? digit_code[owner_src] : code_q;
  assign show_dp   = (cnt_q == '0) ? digit_dp[owner_src]   : dp_q;

  seg7_decode_ext u_decode (
    .code (show_code),
    .dp   (show_dp),
    .seg  (seg_glyph)
  );

  always_comb begin
    any_req = |req;
    low_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (req[i]) low_idx = 2'(i);
    end

    slot_wrap = (cnt_q == CNT_LAST);
    boundary  = slot_wrap && (pos_q == 3'd7);
    cnt_d     = slot_wrap ? '0 : cnt_q + 1'b1;
    pos_d     = slot_wrap ? pos_q + 3'd1 : pos_q;
    tick_d    = boundary;

    owner_d    = owner_q;
    hold_cnt_d = hold_cnt_q;
    if (boundary) begin
      if (!owner_active || !req[owner_src]) begin
        owner_d    = any_req ? owner_of(low_idx) : OWNER_IDLE;
        hold_cnt_d = '0;
      end else if ((low_idx < owner_src) && (hold_cnt_q >= HOLD_MAX)) begin
        owner_d    = owner_of(low_idx);
        hold_cnt_d = '0;
      end else if (hold_cnt_q < HOLD_MAX) begin
        hold_cnt_d = hold_cnt_q + 1'b1;
      end
    end
    gnt_d = owner_d[2] ? (4'b0001 << owner_d[1:0]) : 4'b0000;

    code_d = show_code;
    dp_d   = show_dp;

    if ((cnt_q < CNT_BLANK) || !owner_active) begin
      led_en_d = SEG_BLANK;
      led_cx_d = SEG_BLANK;
    end else begin
      led_en_d = ~(8'b0000_0001 << pos_q);
      led_cx_d = seg_glyph;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      pos_q      <= 3'd0;
      owner_q    <= OWNER_IDLE;
      hold_cnt_q <= '0;
      gnt_q      <= 4'b0000;
      tick_q     <= 1'b0;
      code_q     <= CODE_BLANK;
      dp_q       <= 1'b0;
      led_en_q   <= SEG_BLANK;
      led_cx_q   <= SEG_BLANK;
    end else begin
      cnt_q      <= cnt_d;
      pos_q      <= pos_d;
      owner_q    <= owner_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_q      <= gnt_d;
      tick_q     <= tick_d;
      code_q     <= code_d;
      dp_q       <= dp_d;
      led_en_q   <= led_en_d;
      led_cx_q   <= led_cx_d;
    end
  end

  assign gnt        = gnt_q;
  assign frame_tick = tick_q;
  assign led_en     = led_en_q;
  assign led_cx     = led_cx_q;

endmodule
